// File: rtl/data_read_trigger.sv
// -----------------------------------------------------------------------------
// data_read_trigger
//
// Trigger controller for an LVDS capture path. The four raw lanes pass through
// a fixed-length delay line to the capture stage. Meanwhile an arm/hold/wait
// FSM watches the undelayed lanes for a masked pattern match. When the trigger
// fires, a one-cycle START pulse is sent downstream. Because the lanes are
// delayed by PRE_DEPTH cycles, the capture stage records PRE_DEPTH-1 samples
// from before the trigger event.
//
// Parameters
//   PRE_DEPTH  delay from LVDS_IN to LVDS_OUT in LVDS_CLK cycles (1..64)
//   CNT_W      width of HOLDOFF, TIMEOUT and TRIG_COUNT
//
// Optional feature (macro DATA_READ_TRIG_TIMEOUT_EN)
//   When the macro is defined, an input TIMEOUT is added. A WAIT phase that
//   lasts TIMEOUT cycles (TIMEOUT != 0) fires on its own and sets TIMED_OUT.
//   When the macro is undefined, the port is absent and TIMED_OUT stays 0.
//
// Ports
//   LVDS_CLK      in   sole clock, rising edge
//   LVDS_RESET    in   synchronous reset, active high
//   LVDS_IN       in   [3:0] raw lane samples
//   ARM           in   arm request, level sampled in IDLE only
//   DISARM        in   abort request (HOLD/WAIT), beats ARM in IDLE
//   TRIG_MASK     in   [3:0] lanes taking part in the match
//   TRIG_VALUE    in   [3:0] required lane values
//   TRIG_EDGE     in   1 = fire only on the rising edge of the match
//   HOLDOFF       in   [CNT_W-1:0] cycles spent in HOLD after arming
//   TIMEOUT       in   [CNT_W-1:0] WAIT timeout (macro builds only)
//   CAPTURE_BUSY  in   high while the capture stage writes its buffer
//   LVDS_OUT      out  [3:0] LVDS_IN delayed by PRE_DEPTH cycles
//   START         out  one-cycle capture start pulse
//   ARMED         out  high while in WAIT
//   TRIGGERED     out  high while in FIRED
//   TRIG_COUNT    out  [CNT_W-1:0] fired-trigger count, wraps to 0
//   TIMED_OUT     out  last fire came from the timeout
//   state_dbg     out  [1:0] raw FSM state, for checkers and debug
//
// Capture handshake: START is a single-cycle strobe and is never held. After
// START, the capture stage raises CAPTURE_BUSY for as long as it writes. The
// controller stays in FIRED until it samples CAPTURE_BUSY high and then low.
// It re-enters IDLE on the cycle after that low sample. If CAPTURE_BUSY never
// rises, FIRED persists until reset.
// -----------------------------------------------------------------------------
module data_read_trigger #(
    parameter int PRE_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             LVDS_CLK,
    input  logic             LVDS_RESET,
    input  logic [3:0]       LVDS_IN,
    input  logic             ARM,
    input  logic             DISARM,
    input  logic [3:0]       TRIG_MASK,
    input  logic [3:0]       TRIG_VALUE,
    input  logic             TRIG_EDGE,
    input  logic [CNT_W-1:0] HOLDOFF,
`ifdef DATA_READ_TRIG_TIMEOUT_EN
    input  logic [CNT_W-1:0] TIMEOUT,
`endif
    input  logic             CAPTURE_BUSY,
    output logic [3:0]       LVDS_OUT,
    output logic             START,
    output logic             ARMED,
    output logic             TRIGGERED,
    output logic [CNT_W-1:0] TRIG_COUNT,
    output logic             TIMED_OUT,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIRED = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             prev_match;
    logic             busy_seen;
    logic             timed_out_q;

    // ------------------------------------------------------------------
    // Pre-trigger delay line: shifts every cycle, whatever the FSM is doing.
    // ------------------------------------------------------------------
    logic [3:0] delay_q [PRE_DEPTH];

    always_ff @(posedge LVDS_CLK) begin
        if (LVDS_RESET) begin
            for (int i = 0; i < PRE_DEPTH; i++) begin
                delay_q[i] <= 4'd0;
            end
        end else begin
            delay_q[0] <= LVDS_IN;
            for (int i = 1; i < PRE_DEPTH; i++) begin
                delay_q[i] <= delay_q[i-1];
            end
        end
    end

    assign LVDS_OUT = delay_q[PRE_DEPTH-1];

    // ------------------------------------------------------------------
    // Match and fire terms
    // ------------------------------------------------------------------
    logic match;
    logic match_fire;
    logic timeout_fire;
    logic fire;

    // Unmasked lanes are don't-care. A zero mask therefore matches always.
    assign match      = ((LVDS_IN ^ TRIG_VALUE) & TRIG_MASK) == 4'd0;
    assign match_fire = TRIG_EDGE ? (match & ~prev_match) : match;

`ifdef DATA_READ_TRIG_TIMEOUT_EN
    // Counts the cycles spent in WAIT. It holds 0 in every other state, so it
    // reads 0 on the first WAIT cycle.
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge LVDS_CLK) begin
        if (LVDS_RESET) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_fire = (TIMEOUT != '0) && (wait_cnt == TIMEOUT);
`else
    assign timeout_fire = 1'b0;
`endif

    assign fire = match_fire | timeout_fire;

    // ------------------------------------------------------------------
    // Trigger FSM. State and all status outputs are registered together.
    // ------------------------------------------------------------------
    always_ff @(posedge LVDS_CLK) begin
        if (LVDS_RESET) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            prev_match  <= 1'b0;
            busy_seen   <= 1'b0;
            timed_out_q <= 1'b0;
            START       <= 1'b0;
            ARMED       <= 1'b0;
            TRIGGERED   <= 1'b0;
            TRIG_COUNT  <= '0;
        end else begin
            prev_match <= match;
            START      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // DISARM beats a simultaneous ARM.
                    if (ARM && !DISARM) begin
                        timed_out_q <= 1'b0;
                        if (HOLDOFF == '0) begin
                            state <= ST_WAIT;
                            ARMED <= 1'b1;
                        end else begin
                            state    <= ST_HOLD;
                            hold_cnt <= HOLDOFF;
                        end
                    end
                end

                ST_HOLD: begin
                    // Leaving when the counter reads 1 gives exactly HOLDOFF
                    // cycles in HOLD.
                    hold_cnt <= hold_cnt - CNT_W'(1);
                    if (DISARM) begin
                        state <= ST_IDLE;
                    end else if (hold_cnt == CNT_W'(1)) begin
                        state <= ST_WAIT;
                        ARMED <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    // An abort in the same cycle as a fire wins: no START and
                    // no count.
                    if (DISARM) begin
                        state <= ST_IDLE;
                        ARMED <= 1'b0;
                    end else if (fire) begin
                        state       <= ST_FIRED;
                        ARMED       <= 1'b0;
                        TRIGGERED   <= 1'b1;
                        START       <= 1'b1;
                        TRIG_COUNT  <= TRIG_COUNT + CNT_W'(1);
                        // A real match takes credit over a coincident timeout.
                        timed_out_q <= timeout_fire & ~match_fire;
                        busy_seen   <= 1'b0;
                    end
                end

                ST_FIRED: begin
                    // Ignores ARM and DISARM; only the capture stage's falling
                    // busy releases it.
                    if (busy_seen && !CAPTURE_BUSY) begin
                        state     <= ST_IDLE;
                        TRIGGERED <= 1'b0;
                    end else if (CAPTURE_BUSY) begin
                        busy_seen <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // In builds without the timeout, timeout_fire is tied low, so this
    // register can never leave its reset value of 0.
    assign TIMED_OUT = timed_out_q;
    assign state_dbg = state;

endmodule
